// File: rtl/keyboard_hex_entry.sv
// keyboard_hex_entry: PS/2 scan-code decoder that assembles signed hex entries and commits them on Enter
module keyboard_hex_entry #(
  parameter int DIGITS    = 8,
  parameter int OUT_W     = 32,
  parameter int SIGNED_EN = 1,
  parameter int REPEAT_EN = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   scan_code,
  input  logic                         scan_valid,
  output logic [4*DIGITS-1:0]          entry_data,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         neg,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overflow,
  output logic                         drop
);
  localparam int MW = 4*DIGITS;
  localparam int CW = $clog2(DIGITS+1);
  localparam logic [CW-1:0] MAXC = CW'(DIGITS);
  localparam logic [1:0] IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2;

  logic [1:0]       r_state;
  logic [8:0]       r_last;
  logic [MW-1:0]    r_mag;
  logic [CW-1:0]    r_count;
  logic             r_neg, r_valid, r_ovf, r_drop;
  logic [OUT_W-1:0] r_out;
  logic             w_make, w_act, w_ext, w_hex, w_enter, w_commit;
  logic [3:0]       w_nib;
  logic [8:0]       w_key;
  logic [OUT_W-1:0] w_zext;

  always_comb begin
    w_hex = 1'b1;
    w_nib = 4'h0;
    case (scan_code)
      8'h45: w_nib = 4'h0;
      8'h16: w_nib = 4'h1;
      8'h1E: w_nib = 4'h2;
      8'h26: w_nib = 4'h3;
      8'h25: w_nib = 4'h4;
      8'h2E: w_nib = 4'h5;
      8'h36: w_nib = 4'h6;
      8'h3D: w_nib = 4'h7;
      8'h3E: w_nib = 4'h8;
      8'h46: w_nib = 4'h9;
      8'h1C: w_nib = 4'hA;
      8'h32: w_nib = 4'hB;
      8'h21: w_nib = 4'hC;
      8'h23: w_nib = 4'hD;
      8'h24: w_nib = 4'hE;
      8'h2B: w_nib = 4'hF;
      default: w_hex = 1'b0;
    endcase
  end

  // A make is any byte that is not a prefix and does not follow F0
  assign w_make   = scan_valid && scan_code != 8'hF0 &&
                    (r_state == EXT || (r_state == IDLE && scan_code != 8'hE0));
  assign w_ext    = r_state == EXT;
  assign w_key    = {w_ext, scan_code};
  assign w_act    = w_make && (REPEAT_EN != 0 || w_key != r_last);
  assign w_enter  = w_act && scan_code == 8'h5A;
  assign w_commit = w_enter && (!r_valid || out_ready);
  assign w_zext   = OUT_W'(r_mag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= '0;
      r_mag   <= '0;
      r_count <= '0;
      r_neg   <= 1'b0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_ovf  <= 1'b0;
      r_drop <= 1'b0;
      if (r_valid && out_ready) r_valid <= 1'b0;
      if (scan_valid) begin
        r_state <= (r_state != BRK && scan_code == 8'hF0) ? BRK :
                   (r_state == IDLE && scan_code == 8'hE0) ? EXT : IDLE;
        if (r_state == BRK) r_last <= '0;
      end
      if (w_act) r_last <= w_key;
      if (w_act && !w_ext && w_hex) begin
        if (r_count < MAXC) begin
          r_mag   <= (r_mag << 4) | MW'(w_nib);
          r_count <= r_count + 1'b1;
        end else r_ovf <= 1'b1;
      end
      if (w_act && !w_ext && scan_code == 8'h66 && r_count != '0) begin
        r_mag   <= r_mag >> 4;
        r_count <= r_count - 1'b1;
      end
      if (w_act && !w_ext && scan_code == 8'h76) begin
        r_mag   <= '0;
        r_count <= '0;
        r_neg   <= 1'b0;
      end
      if (w_act && !w_ext && scan_code == 8'h4E && SIGNED_EN != 0) r_neg <= ~r_neg;
      if (w_commit) begin
        r_out   <= r_neg ? -w_zext : w_zext;
        r_valid <= 1'b1;
        r_mag   <= '0;
        r_count <= '0;
        r_neg   <= 1'b0;
      end else if (w_enter) r_drop <= 1'b1;
    end
  end

  assign entry_data  = r_mag;
  assign digit_count = r_count;
  assign neg         = r_neg;
  assign out_data    = r_out;
  assign out_valid   = r_valid;
  assign overflow    = r_ovf;
  assign drop        = r_drop;
endmodule
